mostra_sequencia: RTL and testbench
===================================

Name: mostra_sequencia

Overview:
Presents the stored jogada sequence to the player by reading the 16x4 synchronous ROM and lighting one LED pattern per address. It is the output side of the game: it shows addresses 0..limite, and the player then echoes them back through the botoes/comparison path. On the iniciar pulse the block owns the ROM address bus until it asserts pronto. It sits beside the fluxo_dados path and is sequenced by the game control unit.

Parameters:
TEMPO_ACESO, 500, clock cycles each pattern stays lit (0.5 s at 1 kHz); must be at least 1
TEMPO_APAGADO, 250, clock cycles of dark gap after each pattern; must be at least 1
N, 10, width of the internal interval timer; 2^N must be at least max(TEMPO_ACESO, TEMPO_APAGADO)

Ports:
clock  in  1  system clock, all logic on its rising edge
reset  in  1  synchronous, active-high; forces INICIAL
iniciar  in  1  start request; sampled only in INICIAL
limite  in  4  last address to show; captured on start
dado  in  4  ROM data_out; valid one cycle after endereco changes
endereco  out  4  ROM address
leds  out  4  pattern shown to player
ocupado  out  1  high in every state except INICIAL
pronto  out  1  one-cycle pulse when the sequence is complete
db_estado  out  3  current state code for debug

Behaviour:
- Reset (synchronous, active-high): state becomes INICIAL; endereco=0, leds=0, ocupado=0, pronto=0, timer=0, limite register=0.
- State codes: INICIAL=0, CARREGA=1, LE_MEM=2, ACENDE=3, APAGA=4, PROXIMO=5, FIM=6. Code 7 is unused and goes to INICIAL on the next edge.
- INICIAL: leds=0.
  - If iniciar=1: capture limite into a register, set endereco to 0, go to CARREGA.
  - Otherwise stay.
- CARREGA: endereco is held stable for one cycle so the ROM registers it; go to LE_MEM.
- LE_MEM: load leds from dado, clear the timer, go to ACENDE.
- ACENDE: hold leds and increment the timer.
  - When timer = TEMPO_ACESO-1: set leds to 0, clear the timer, go to APAGA.
  - Result: leds are lit for exactly TEMPO_ACESO cycles.
- APAGA: leds=0, increment the timer. When timer = TEMPO_APAGADO-1, go to PROXIMO.
- PROXIMO:
  - If endereco equals the captured limite: go to FIM.
  - Otherwise increment endereco and go to CARREGA.
- FIM: pronto=1 for this single cycle; go to INICIAL.
- Cost: each element takes TEMPO_ACESO+TEMPO_APAGADO+3 cycles. FIM adds one cycle at the end.
- iniciar is ignored while ocupado=1. Changes to limite during a run are ignored.
- limite=15 shows all 16 addresses. endereco never wraps; it stops at 15 and the run goes to FIM.
- limite=0 shows exactly one element (address 0).
- Reset mid-run: INICIAL on the next edge, leds go dark immediately at that edge, and no pronto is generated.
- reset and iniciar asserted together: reset wins.
- A zero dado value still consumes its full lit/dark slot, with leds=0 during it.

Optional Feature:
Macro: MOSTRA_SEQUENCIA_ABORTA_EN
- Defined:
  - Adds input port abortar (1 bit).
  - abortar=1 in any state other than INICIAL forces leds=0, endereco=0 and state INICIAL at the next edge, with no pronto pulse.
  - Has priority over all transitions except reset.
- Undefined: the abortar port does not exist, and a run can only be ended by completion or by reset.

Test Plan:
1. Params TEMPO_ACESO=4, TEMPO_APAGADO=2; ROM[0]=0001, ROM[1]=0010, limite=1; iniciar pulse sampled at edge 0 ->
   - leds=0001 in cycles 3-6 and 0010 in cycles 12-15;
   - leds=0 in cycles 7-9 and 16-18;
   - pronto=1 only in cycle 19;
   - ocupado=1 in cycles 1-19 and 0 from cycle 20.
2. limite=0, same params -> only address 0 shown; endereco never exceeds 0; pronto in cycle 10.
3. limite=15, ROM holding 0001,0010,0100,1000 repeated -> 16 patterns in address order; endereco ends at 15 with no wrap; pronto after 16×9+1 cycles.
4. Second iniciar pulse at cycle 5 of a run, and limite changed to 7 mid-run -> the run is unaffected; same timing and pronto as scenario 1.
5. reset=1 in cycle 13 of scenario 1 -> at the next edge leds=0, endereco=0, db_estado=0, ocupado=0; no pronto ever appears; a new iniciar restarts from address 0.
6. With MOSTRA_SEQUENCIA_ABORTA_EN defined, abortar=1 in cycle 4 -> INICIAL at the next edge, leds=0, no pronto. Without the macro, the bench compiles without the abortar port.

Source files
------------

// File: rtl/mostra_sequencia.sv
// rtl/mostra_sequencia.sv - shows ROM addresses 0..limite as timed LED patterns
// Optional abort input enabled by defining MOSTRA_SEQUENCIA_ABORTA_EN.
module mostra_sequencia #(
    parameter int TEMPO_ACESO   = 500,
    parameter int TEMPO_APAGADO = 250,
    parameter int N             = 10
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic [3:0] limite,
    input  logic [3:0] dado,
`ifdef MOSTRA_SEQUENCIA_ABORTA_EN
    input  logic       abortar,
`endif
    output logic [3:0] endereco,
    output logic [3:0] leds,
    output logic       ocupado,
    output logic       pronto,
    output logic [2:0] db_estado
);

    localparam logic [2:0] INICIAL = 3'd0;
    localparam logic [2:0] CARREGA = 3'd1;
    localparam logic [2:0] LE_MEM  = 3'd2;
    localparam logic [2:0] ACENDE  = 3'd3;
    localparam logic [2:0] APAGA   = 3'd4;
    localparam logic [2:0] PROXIMO = 3'd5;
    localparam logic [2:0] FIM     = 3'd6;

    localparam logic [N-1:0] FIM_ACESO   = N'(TEMPO_ACESO - 1);
    localparam logic [N-1:0] FIM_APAGADO = N'(TEMPO_APAGADO - 1);
    localparam logic [N-1:0] UM          = N'(1);

    logic [2:0]   estado;
    logic [N-1:0] timer;
    logic [3:0]   limite_reg;

    assign ocupado   = (estado != INICIAL);
    assign pronto    = (estado == FIM);
    assign db_estado = estado;

    always_ff @(posedge clock) begin
        if (reset) begin
            estado     <= INICIAL;
            endereco   <= 4'd0;
            leds       <= 4'd0;
            timer      <= '0;
            limite_reg <= 4'd0;
        end
`ifdef MOSTRA_SEQUENCIA_ABORTA_EN
        else if (abortar && (estado != INICIAL)) begin
            estado   <= INICIAL;
            leds     <= 4'd0;
            endereco <= 4'd0;
        end
`endif
        else begin
            case (estado)
                INICIAL: begin
                    leds <= 4'd0;
                    if (iniciar) begin
                        limite_reg <= limite;
                        endereco   <= 4'd0;
                        estado     <= CARREGA;
                    end
                end
                // ROM needs a full cycle with a stable address before dado is valid
                CARREGA: estado <= LE_MEM;
                LE_MEM: begin
                    leds   <= dado;
                    timer  <= '0;
                    estado <= ACENDE;
                end
                ACENDE: begin
                    if (timer == FIM_ACESO) begin
                        leds   <= 4'd0;
                        timer  <= '0;
                        estado <= APAGA;
                    end else begin
                        timer <= timer + UM;
                    end
                end
                APAGA: begin
                    leds <= 4'd0;
                    if (timer == FIM_APAGADO) begin
                        timer  <= '0;
                        estado <= PROXIMO;
                    end else begin
                        timer <= timer + UM;
                    end
                end
                PROXIMO: begin
                    if (endereco == limite_reg) begin
                        estado <= FIM;
                    end else begin
                        endereco <= endereco + 4'd1;
                        estado   <= CARREGA;
                    end
                end
                FIM: estado <= INICIAL;
                default: begin
                    leds   <= 4'd0;
                    estado <= INICIAL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mostra_sequencia.sv
// tb/tb_mostra_sequencia.sv - directed cycle-by-cycle bench for mostra_sequencia
module tb_mostra_sequencia;

    localparam int TA = 4;
    localparam int TD = 2;
    localparam int P  = TA + TD + 3;

    logic       clock = 1'b0;
    logic       reset;
    logic       iniciar;
    logic [3:0] limite;
    logic [3:0] dado;
    logic [3:0] endereco;
    logic [3:0] leds;
    logic       ocupado;
    logic       pronto;
    logic [2:0] db_estado;
`ifdef MOSTRA_SEQUENCIA_ABORTA_EN
    logic       abortar = 1'b0;
`endif

    logic [3:0] rom [16];
    int n_checks = 0;
    int n_errors = 0;

    mostra_sequencia #(.TEMPO_ACESO(TA), .TEMPO_APAGADO(TD), .N(10)) dut (
        .clock     (clock),
        .reset     (reset),
        .iniciar   (iniciar),
        .limite    (limite),
        .dado      (dado),
`ifdef MOSTRA_SEQUENCIA_ABORTA_EN
        .abortar   (abortar),
`endif
        .endereco  (endereco),
        .leds      (leds),
        .ocupado   (ocupado),
        .pronto    (pronto),
        .db_estado (db_estado)
    );

    always #5 clock = ~clock;

    always_ff @(posedge clock) dado <= rom[endereco];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Starts a run with iniciar in cycle 0 and checks every cycle until two past FIM.
    // rst_k/ab_k/pulse2_k/chg_k: cycle to assert reset/abortar/extra iniciar/limite=7 (0 = never).
    task automatic run_seq(input string name, input int lim, input int rst_k,
                           input int ab_k, input int pulse2_k, input int chg_k);
        int total;
        int stop;
        total = (lim + 1) * P + 1;
        stop  = rst_k;
`ifdef MOSTRA_SEQUENCIA_ABORTA_EN
        if (ab_k > 0 && (stop == 0 || ab_k < stop)) stop = ab_k;
`endif
        limite  = lim[3:0];
        iniciar = 1'b1;
        @(posedge clock);
        for (int k = 1; k <= total + 2; k++) begin
            logic [2:0] es;
            logic [3:0] el;
            logic [3:0] ee;
            logic       eo;
            logic       ep;
            int e;
            int p;
            #1;
            iniciar = (k == pulse2_k);
            reset   = (k == rst_k);
`ifdef MOSTRA_SEQUENCIA_ABORTA_EN
            abortar = (k == ab_k);
`endif
            if (k == chg_k) limite = 4'd7;
            @(negedge clock);
            el = 4'd0; ep = 1'b0; eo = 1'b1;
            if (stop > 0 && k > stop) begin
                es = 3'd0; ee = 4'd0; eo = 1'b0;
            end else if (k > total) begin
                es = 3'd0; ee = lim[3:0]; eo = 1'b0;
            end else if (k == total) begin
                es = 3'd6; ee = lim[3:0]; ep = 1'b1;
            end else begin
                e  = (k - 1) / P;
                p  = (k - 1) % P;
                ee = e[3:0];
                if (p == 0)                es = 3'd1;
                else if (p == 1)           es = 3'd2;
                else if (p < TA + 2)       begin es = 3'd3; el = rom[e]; end
                else if (p < TA + TD + 2)  es = 3'd4;
                else                       es = 3'd5;
            end
            check($sformatf("%s c%0d leds", name, k), 32'(leds), 32'(el));
            check($sformatf("%s c%0d pronto", name, k), 32'(pronto), 32'(ep));
            check($sformatf("%s c%0d ocupado", name, k), 32'(ocupado), 32'(eo));
            check($sformatf("%s c%0d endereco", name, k), 32'(endereco), 32'(ee));
            check($sformatf("%s c%0d estado", name, k), 32'(db_estado), 32'(es));
            @(posedge clock);
        end
        #1;
        reset   = 1'b0;
        iniciar = 1'b0;
`ifdef MOSTRA_SEQUENCIA_ABORTA_EN
        abortar = 1'b0;
`endif
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rom[i] = 4'(1 << (i % 4));
        reset   = 1'b1;
        iniciar = 1'b1;
        limite  = 4'd5;
        @(posedge clock);
        @(posedge clock);
        #1;
        check("reset leds", 32'(leds), 32'd0);
        check("reset endereco", 32'(endereco), 32'd0);
        check("reset ocupado", 32'(ocupado), 32'd0);
        check("reset pronto", 32'(pronto), 32'd0);
        check("reset estado", 32'(db_estado), 32'd0);
        reset   = 1'b0;
        iniciar = 1'b0;
        @(posedge clock);
        #1;
        check("idle estado", 32'(db_estado), 32'd0);

        run_seq("s1_lim1", 1, 0, 0, 0, 0);
        run_seq("s2_lim0", 0, 0, 0, 0, 0);
        run_seq("s3_lim15", 15, 0, 0, 0, 0);
        run_seq("s4_ignore", 1, 0, 0, 5, 8);
        run_seq("s5_reset", 1, 13, 0, 0, 0);
        run_seq("s5_restart", 1, 0, 0, 0, 0);
`ifdef MOSTRA_SEQUENCIA_ABORTA_EN
        run_seq("s6_abort", 1, 0, 4, 0, 0);
        run_seq("s6_restart", 1, 0, 0, 0, 0);
`endif
        rom[0] = 4'd0;
        run_seq("zero_dado", 0, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
